keccak_absorb_padder: RTL and testbench

Front-end producer for the Keccak-256 core. It accepts a message as a stream of 64-bit little-endian words with a valid/ready handshake. It packs the words into 1088-bit rate blocks (17 lanes), applies Keccak multi-rate padding (pad10*1), and presents each completed block to the hash core over a valid/ready handshake, with a last-block flag. It is the writer side of the core's absorb interface and owns all message framing and padding.

---
 rtl/keccak_absorb_padder.sv | 180 ++++++++++++++++++
 tb/tb_keccak_absorb_padder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_absorb_padder.sv
// keccak_absorb_padder
// Packs a stream of 64-bit little-endian message words into Keccak rate
// blocks, applies pad10*1 multi-rate padding with a configurable domain byte,
// and hands each finished block to the permutation core over valid/ready.
// Words and blocks never overlap: while a block is pending, no input is taken.

module keccak_absorb_padder #(
  parameter int          RATE_LANES = 17,
  parameter logic [7:0]  PAD_BYTE   = 8'h01
) (
  input  logic                       clk,
  input  logic                       rst,        // synchronous, active-low
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                in_data,
  input  logic                       in_last,
  input  logic [3:0]                 in_bytes,
  output logic                       blk_valid,
  input  logic                       blk_ready,
  output logic [RATE_LANES*64-1:0]   blk_data,
  output logic                       blk_last,
  output logic                       busy
);

  localparam int BLK_W = RATE_LANES * 64;
  localparam int CNT_W = $clog2(RATE_LANES + 1);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATE_LANES - 1);

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    SEND     = 2'd1,
    SEND_PAD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               blk_last_q, blk_last_d;
  logic               pad_pend_q, pad_pend_d;
  logic               busy_q, busy_d;

  // Decoded view of the incoming last word.
  logic [3:0]         n_bytes;
  logic [63:0]        last_lane;
  logic               exact_fill;
  logic               in_fire;
  logic               blk_fire;

  // Output drive: ready is also suppressed while reset is held.
  assign in_ready  = rst && (state_q == FILL);
  assign blk_valid = (state_q != FILL);
  assign blk_data  = buf_q;
  assign blk_last  = blk_last_q;
  assign busy      = busy_q;

  assign in_fire  = in_valid && in_ready;
  assign blk_fire = blk_valid && blk_ready;

  // Build the lane holding the final message bytes: data, then the pad
  // start byte right after them, zeros above.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
    n_bytes   = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    last_lane = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < n_bytes) begin
        last_lane[8*k +: 8] = in_data[8*k +: 8];
      end else if (4'(k) == n_bytes) begin
        last_lane[8*k +: 8] = PAD_BYTE;
      end
    end
    // A full final word in the top lane leaves no room for padding here;
    // the padding then travels in a separate pad-only block.
    exact_fill = in_last && (n_bytes == 4'd8) && (cnt_q == LAST_LANE);
  end

  // Next-state logic for the framing FSM, lane buffer and flags.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    blk_last_d = blk_last_q;
    pad_pend_d = pad_pend_q;
    busy_d     = busy_q;

    unique case (state_q)
      FILL: begin
        if (in_fire) begin
          busy_d = 1'b1;
          for (int l = 0; l < RATE_LANES; l++) begin
            if (CNT_W'(l) == cnt_q) begin
              buf_d[64*l +: 64] = in_last ? last_lane : in_data;
            end else if (in_last && (n_bytes == 4'd8) &&
                         (CNT_W'(l) == cnt_q + CNT_W'(1))) begin
              // Full final word: padding starts in the following lane.
              buf_d[64*l +: 64] = {56'd0, PAD_BYTE};
            end
          end

          if (in_last) begin
            cnt_d   = '0;
            state_d = SEND;
            if (exact_fill) begin
              blk_last_d = 1'b0;
              pad_pend_d = 1'b1;
            end else begin
              // Closing bit of pad10*1 sits in the top bit of the block;
              // it merges with PAD_BYTE when both land on the last byte.
              buf_d[BLK_W-1] = 1'b1;
              blk_last_d     = 1'b1;
            end
          end else if (cnt_q == LAST_LANE) begin
            cnt_d      = '0;
            blk_last_d = 1'b0;
            state_d    = SEND;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      SEND: begin
        if (blk_fire) begin
          buf_d = '0;
          cnt_d = '0;
          if (pad_pend_q) begin
            buf_d[7:0]     = PAD_BYTE;
            buf_d[BLK_W-1] = 1'b1;
            blk_last_d     = 1'b1;
            state_d        = SEND_PAD;
          end else begin
            if (blk_last_q) begin
              busy_d = 1'b0;
            end
            blk_last_d = 1'b0;
            state_d    = FILL;
          end
        end
      end

      SEND_PAD: begin
        if (blk_fire) begin
          buf_d      = '0;
          cnt_d      = '0;
          blk_last_d = 1'b0;
          pad_pend_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = FILL;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State register with synchronous active-low reset; a reset discards any
  // partial message and any block not yet taken by the core.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the lane buffer is reset because it drives blk_data directly and must read zero out of reset.
      state_q    <= FILL;
      buf_q      <= '0;
      cnt_q      <= '0;
      blk_last_q <= 1'b0;
      pad_pend_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values computed above.
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      blk_last_q <= blk_last_d;
      pad_pend_q <= pad_pend_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_keccak_absorb_padder.sv
// Bench for keccak_absorb_padder: a byte-level pad10*1 model produces the
// expected block sequence for each message; a compare process checks every
// block handshake and the hold/exclusivity rules each cycle, and directed
// literal checks pin the model on the classic vectors.

module tb_keccak_absorb_padder;

  localparam int         LANES = 17;
  localparam int         RBYTES = LANES * 8;
  localparam int         BW = LANES * 64;
  localparam logic [7:0] PADB = 8'h01;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          blk_valid;
  logic          blk_ready;
  logic [BW-1:0] blk_data;
  logic          blk_last;
  logic          busy;

  keccak_absorb_padder #(.RATE_LANES(LANES), .PAD_BYTE(PADB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] d;
    logic          l;
  } blk_t;

  int            tests = 0;
  int            fails = 0;
  blk_t          exp_q[$];
  logic [7:0]    msg_q[$];
  logic [BW-1:0] got_blk;
  logic          got_last;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: pad the whole message at byte level, then slice into blocks.
  task automatic model_push();
    int         len = msg_q.size();
    int         plen = ((len + 1 + RBYTES - 1) / RBYTES) * RBYTES;
    logic [7:0] p[];
    blk_t       b;
    p = new[plen];
    for (int i = 0; i < plen; i++) p[i] = (i < len) ? msg_q[i] : 8'h00;
    p[len]      = p[len] | PADB;
    p[plen - 1] = p[plen - 1] | 8'h80;
    for (int bi = 0; bi < plen / RBYTES; bi++) begin
      for (int k = 0; k < RBYTES; k++) b.d[8*k +: 8] = p[bi*RBYTES + k];
      b.l = (bi == plen / RBYTES - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Drive msg_q as words; bytes past the valid count carry junk (8'hEE).
  task automatic send_msg(input int nb_over);
    int          len = msg_q.size();
    int          nw = (len == 0) ? 1 : (len + 7) / 8;
    int          nlast = len - 8 * (nw - 1);
    logic [63:0] w;
    model_push();
    for (int wi = 0; wi < nw; wi++) begin
      for (int k = 0; k < 8; k++)
        w[8*k +: 8] = (8*wi + k < len) ? msg_q[8*wi + k] : 8'hEE;
      if (wi == nw - 1)
        send_word(w, 1'b1, (nb_over >= 0) ? 4'(nb_over) : 4'(nlast));
      else
        send_word(w, 1'b0, 4'd8);
    end
  endtask

  task automatic make_msg(input int len, input int seed);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'((i * 7 + seed) & 8'hFF));
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("drain", BW'(exp_q.size()), BW'(0));
    @(posedge clk); #1;
    check("busy_after_msg", busy, 1'b0);
    check("ready_after_msg", in_ready, 1'b1);
  endtask

  // Compare process: handshakes against the model, hold rule, exclusivity.
  initial begin
    logic          hold = 1'b0;
    logic [BW-1:0] hd;
    logic          hl;
    blk_t          e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        hold = 1'b0;
      end else begin
        check("ready_vs_valid", in_ready, !blk_valid);
        if (hold) begin
          check("hold_valid", blk_valid, 1'b1);
          check("hold_data", blk_data, hd);
          check("hold_last", blk_last, hl);
        end
        if (blk_valid && blk_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_block", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("blk_data", blk_data, e.d);
            check("blk_last", blk_last, e.l);
          end
          got_blk  = blk_data;
          got_last = blk_last;
        end
        hold = blk_valid && !blk_ready;
        hd   = blk_data;
        hl   = blk_last;
      end
    end
  end

  initial begin
    logic [BW-1:0] held;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_bytes = '0; blk_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_blk_valid", blk_valid, 1'b0);
    check("rst_blk_last", blk_last, 1'b0);
    check("rst_blk_data", blk_data, '0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Empty message.
    msg_q.delete();
    send_msg(-1);
    wait_drain();
    check("empty_lane0", got_blk[63:0], 64'h01);
    check("empty_lane16", got_blk[BW-1 -: 64], 64'h8000000000000000);
    check("empty_mid", got_blk[BW-65:64], '0);
    check("empty_last", got_last, 1'b1);

    // "abc".
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(-1);
    wait_drain();
    check("abc_lane0", got_blk[63:0], 64'h0000000001636261);
    check("abc_lane16", got_blk[BW-1 -: 64], 64'h8000000000000000);

    // 135 bytes: pad byte and closing bit share the final byte.
    make_msg(135, 3);
    send_msg(-1);
    wait_drain();
    check("b135_top", got_blk[BW-1 -: 8], 8'h81);
    check("b135_last", got_last, 1'b1);

    // 136 bytes: exact fill, then a pad-only block.
    make_msg(136, 5);
    send_msg(-1);
    wait_drain();
    check("b136_pad_lane0", got_blk[63:0], 64'h01);
    check("b136_pad_lane16", got_blk[BW-1 -: 64], 64'h8000000000000000);
    check("b136_pad_last", got_last, 1'b1);

    // Multi-block, partial-word tail, then a full last word with in_bytes=15.
    make_msg(300, 11);
    send_msg(-1);
    wait_drain();
    make_msg(20, 17);
    send_msg(-1);
    wait_drain();
    make_msg(8, 29);
    send_msg(15);
    wait_drain();
    check("clamp_lane1", got_blk[127:64], 64'h01);

    // Backpressure: the block must hold for five refused cycles.
    blk_ready = 1'b0;
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(-1);
    held = blk_data;
    check("bp_lane0", held[63:0], 64'h0000000001636261);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", blk_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_data", blk_data, held);
      check("bp_last", blk_last, 1'b1);
      @(posedge clk); #1;
    end
    blk_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_after_ready", in_ready, 1'b1);
    check("bp_after_valid", blk_valid, 1'b0);
    check("bp_after_data", blk_data, '0);
    check("bp_after_busy", busy, 1'b0);
    check("bp_drained", BW'(exp_q.size()), BW'(0));

    // Reset after five accepted lanes discards the partial message.
    for (int i = 0; i < 5; i++) send_word(64'h1111111111111111 * 64'(i + 1), 1'b0, 4'd8);
    check("mid_busy", busy, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", blk_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_data", blk_data, '0);
    rst = 1'b1;
    #1;
    check("mid_release_ready", in_ready, 1'b1);
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg(-1);
    wait_drain();
    check("mid_abc_lane0", got_blk[63:0], 64'h0000000001636261);
    check("mid_abc_lane16", got_blk[BW-1 -: 64], 64'h8000000000000000);
    check("mid_abc_last", got_last, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
